// File: rtl/uart_alu_sequencer_if.sv
// Bus between the UART/ALU sequencer and its receiver, transmitter and ALU.
// The o_overrun flag exists only when UART_ALU_SEQ_OVERRUN_EN is defined.
interface uart_alu_sequencer_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic               i_tx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic [NB_DATA-1:0] o_alu_a;
    logic [NB_DATA-1:0] o_alu_b;
    logic [NB_OP-1:0]   o_alu_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
`ifdef UART_ALU_SEQ_OVERRUN_EN
    logic               o_overrun;
`endif

    modport master (
        input  i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy
`ifdef UART_ALU_SEQ_OVERRUN_EN
        , output o_overrun
`endif
    );

    modport slave (
        output i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy
`ifdef UART_ALU_SEQ_OVERRUN_EN
        , input o_overrun
`endif
    );
endinterface

// File: rtl/uart_alu_sequencer.sv
// Collects A, B, opcode bytes from the UART receiver, runs the ALU and sends the result back.
// Optional sticky o_overrun flag is enabled with UART_ALU_SEQ_OVERRUN_EN.
module uart_alu_sequencer #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int NB_TIMEOUT     = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    uart_alu_sequencer_if.master bus
);
    localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        GET_OP  = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    state_t state_q, next_state;

    logic [NB_DATA-1:0]    alu_a_q, alu_b_q, tx_data_q;
    logic [NB_OP-1:0]      alu_op_q;
    logic                  tx_start_q, busy_q;
    logic [NB_TIMEOUT-1:0] cnt_q;

    logic load_a, load_b, load_op, load_tx, cnt_clr, cnt_inc;
    logic timeout_hit;

    function automatic logic [NB_TIMEOUT-1:0] sat_inc(input logic [NB_TIMEOUT-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign timeout_hit = (cnt_q >= TIMEOUT_LAST);

    always_ff @(posedge i_clock) begin
        if (i_reset) state_q <= GET_A;
        else         state_q <= next_state;
    end

    always_comb begin
        next_state = state_q;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_op    = 1'b0;
        load_tx    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state_q)
            GET_A: begin
                cnt_clr = 1'b1;
                if (bus.i_rx_done) begin
                    load_a     = 1'b1;
                    next_state = GET_B;
                end
            end
            GET_B: begin
                // A byte arriving on the expiry cycle still counts.
                if (bus.i_rx_done) begin
                    load_b     = 1'b1;
                    cnt_clr    = 1'b1;
                    next_state = GET_OP;
                end else if (timeout_hit) begin
                    cnt_clr    = 1'b1;
                    next_state = GET_A;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            GET_OP: begin
                if (bus.i_rx_done) begin
                    load_op    = 1'b1;
                    cnt_clr    = 1'b1;
                    next_state = EXEC;
                end else if (timeout_hit) begin
                    cnt_clr    = 1'b1;
                    next_state = GET_A;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            EXEC: begin
                load_tx    = 1'b1;
                next_state = SEND;
            end
            SEND: next_state = WAIT_TX;
            WAIT_TX: begin
                if (bus.i_tx_done) begin
                    cnt_clr    = 1'b1;
                    next_state = GET_A;
                end
            end
            default: begin
                cnt_clr    = 1'b1;
                next_state = GET_A;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (load_a)  alu_a_q   <= bus.i_rx_data;
            if (load_b)  alu_b_q   <= bus.i_rx_data;
            if (load_op) alu_op_q  <= bus.i_rx_data[NB_OP-1:0];
            // ALU result is valid one cycle after the opcode register updates.
            if (load_tx) tx_data_q <= bus.i_alu_result;
            tx_start_q <= (next_state == SEND);
            busy_q     <= (next_state == EXEC) || (next_state == SEND) || (next_state == WAIT_TX);
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= sat_inc(cnt_q);
        end
    end

    assign bus.o_alu_a    = alu_a_q;
    assign bus.o_alu_b    = alu_b_q;
    assign bus.o_alu_op   = alu_op_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_start = tx_start_q;
    assign bus.o_busy     = busy_q;

`ifdef UART_ALU_SEQ_OVERRUN_EN
    logic overrun_q;
    logic dropped, expired;

    assign dropped = bus.i_rx_done &&
                     ((state_q == EXEC) || (state_q == SEND) || (state_q == WAIT_TX));
    assign expired = ((state_q == GET_B) || (state_q == GET_OP)) && !bus.i_rx_done && timeout_hit;

    always_ff @(posedge i_clock) begin
        if (i_reset)                overrun_q <= 1'b0;
        else if (dropped || expired) overrun_q <= 1'b1;
    end

    assign bus.o_overrun = overrun_q;
`endif
endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed bench for uart_alu_sequencer with a command-level reference model checked every cycle.
`timescale 1ns/1ps
module tb_uart_alu_sequencer;
    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int NB_TO   = 16;
    localparam int T       = 20;
    localparam int TX_LAT  = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_alu_sequencer_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus();

    uart_alu_sequencer #(
        .NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_TIMEOUT(NB_TO), .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus(bus)
    );

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    assign bus.i_alu_result = alu_f(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: bytes collected so far, idle cycles, and cycles since the opcode arrived.
    int         m_got, m_age, m_idle;
    logic [7:0] m_a, m_b, m_tx;
    logic [5:0] m_op;
    logic       m_start, m_ovr, m_ok;

    initial begin
        m_ok = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_got = 0; m_age = 0; m_idle = 0;
                m_a = 0; m_b = 0; m_op = 0; m_tx = 0;
                m_start = 0; m_ovr = 0; m_ok = 1'b1;
            end else begin
                m_start = 1'b0;
                if (m_got == 0) begin
                    if (bus.i_rx_done) begin m_a = bus.i_rx_data; m_got = 1; m_idle = 0; end
                end else if (m_got < 3) begin
                    if (bus.i_rx_done) begin
                        if (m_got == 1) m_b = bus.i_rx_data;
                        else            m_op = bus.i_rx_data[5:0];
                        m_got++; m_idle = 0; m_age = 0;
                    end else if (m_idle == T - 1) begin
                        m_got = 0; m_idle = 0; m_ovr = 1'b1;
                    end else begin
                        m_idle++;
                    end
                end else begin
                    if (bus.i_rx_done) m_ovr = 1'b1;
                    if (m_age == 0) begin
                        m_tx = alu_f(m_a, m_b, m_op); m_start = 1'b1; m_age = 1;
                    end else if (m_age == 1) begin
                        m_age = 2;
                    end else if (bus.i_tx_done) begin
                        m_got = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_ok) begin
                check("alu_a",    bus.o_alu_a,    m_a);
                check("alu_b",    bus.o_alu_b,    m_b);
                check("alu_op",   bus.o_alu_op,   m_op);
                check("tx_data",  bus.o_tx_data,  m_tx);
                check("tx_start", bus.o_tx_start, m_start);
                check("busy",     bus.o_busy,     (m_got == 3));
`ifdef UART_ALU_SEQ_OVERRUN_EN
                check("overrun",  bus.o_overrun,  m_ovr);
`endif
                if (bus.o_tx_start === 1'b1) n_start++;
            end
        end
    end

    task automatic rx_byte(input logic [7:0] b, input bit lead);
        if (lead) @(negedge clk);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        @(negedge clk);
        bus.i_rx_done = 1'b0;
    endtask

    task automatic get_tx(output logic [7:0] d, output int lat);
        lat = 1;
        d   = 8'h00;
        while (bus.o_tx_start !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (bus.o_tx_start !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL tx_start_wait: no o_tx_start within %0d cycles", lat);
        end else begin
            d = bus.o_tx_data;
        end
    endtask

    task automatic end_tx(input int gap, input bit with_rx, input logic [7:0] rb);
        repeat (gap) @(negedge clk);
        bus.i_tx_done = 1'b1;
        if (with_rx) begin
            bus.i_rx_data = rb;
            bus.i_rx_done = 1'b1;
        end
        @(negedge clk);
        bus.i_tx_done = 1'b0;
        bus.i_rx_done = 1'b0;
    endtask

    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic [7:0] exp, input string nm);
        logic [7:0] d;
        int lat;
        rx_byte(a, 1);
        rx_byte(b, 1);
        rx_byte(op, 1);
        get_tx(d, lat);
        check({nm, "_result"}, d, exp);
        check({nm, "_latency"}, lat, 2);
        end_tx(TX_LAT, 0, 8'h00);
    endtask

    initial begin
        logic [7:0] d;
        int lat, s0;
        bus.i_rx_data = 8'h00;
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_a", bus.o_alu_a, 0);
        check("rst_start", bus.o_tx_start, 0);
        check("rst_busy", bus.o_busy, 0);
        rst = 1'b0;

        run_cmd(8'h05, 8'h03, 8'h20, 8'h08, "add");
        check("add_a", bus.o_alu_a, 8'h05);
        check("add_b", bus.o_alu_b, 8'h03);
        check("add_op", bus.o_alu_op, 6'h20);
        run_cmd(8'h09, 8'h0C, 8'h22, 8'hFD, "sub");
        run_cmd(8'hF0, 8'h3C, 8'hE4, 8'h30, "and_hi_bits");

        // Back-to-back: next A arrives one cycle after tx_done.
        rx_byte(8'h11, 1); rx_byte(8'h22, 1); rx_byte(8'h20, 1);
        get_tx(d, lat);
        check("b2b_first", d, 8'h33);
        end_tx(TX_LAT, 0, 8'h00);
        check("b2b_busy_gap", bus.o_busy, 0);
        rx_byte(8'h44, 0); rx_byte(8'h01, 1); rx_byte(8'h26, 1);
        get_tx(d, lat);
        check("b2b_second", d, 8'h45);
        end_tx(TX_LAT, 0, 8'h00);

        // Timeout in GET_B: 0xAA is abandoned and never transmitted.
        s0 = n_start;
        rx_byte(8'hAA, 1);
        repeat (25) @(negedge clk);
        check("to_hold_a", bus.o_alu_a, 8'hAA);
        check("to_idle_busy", bus.o_busy, 0);
        run_cmd(8'h01, 8'h02, 8'h20, 8'h03, "to_cmd");
        check("to_one_tx", n_start - s0, 1);
        check("to_new_a", bus.o_alu_a, 8'h01);

        // Timeout in GET_OP.
        rx_byte(8'h30, 1); rx_byte(8'h31, 1);
        repeat (25) @(negedge clk);
        run_cmd(8'h02, 8'h02, 8'h20, 8'h04, "to_op");

        // Byte on the expiry cycle is accepted as B.
        rx_byte(8'h10, 1);
        repeat (18) @(negedge clk);
        rx_byte(8'h07, 1);
        check("expiry_b", bus.o_alu_b, 8'h07);
        rx_byte(8'h20, 1);
        get_tx(d, lat);
        check("expiry_result", d, 8'h17);
        end_tx(TX_LAT, 0, 8'h00);

        // One cycle later the command has already been abandoned.
        rx_byte(8'h10, 1);
        repeat (19) @(negedge clk);
        rx_byte(8'h04, 1);
        check("late_as_a", bus.o_alu_a, 8'h04);
        rx_byte(8'h05, 1); rx_byte(8'h20, 1);
        get_tx(d, lat);
        check("late_result", d, 8'h09);
        end_tx(TX_LAT, 0, 8'h00);

        // Drops while busy.
        rx_byte(8'h0A, 1); rx_byte(8'h0B, 1); rx_byte(8'h20, 1);
        get_tx(d, lat);
        check("drop_result", d, 8'h15);
        repeat (2) @(negedge clk);
        rx_byte(8'hFF, 1);
        check("drop_a", bus.o_alu_a, 8'h0A);
        check("drop_busy", bus.o_busy, 1);
`ifdef UART_ALU_SEQ_OVERRUN_EN
        check("drop_overrun", bus.o_overrun, 1);
`endif
        end_tx(3, 0, 8'h00);
        rx_byte(8'h01, 1); rx_byte(8'h01, 1); rx_byte(8'h20, 1);
        get_tx(d, lat);
        check("simul_result", d, 8'h02);
        end_tx(2, 1, 8'hEE);
        repeat (3) @(negedge clk);
        check("simul_a", bus.o_alu_a, 8'h01);
        check("simul_busy", bus.o_busy, 0);
        run_cmd(8'h03, 8'h04, 8'h20, 8'h07, "after_drop");

        // Reset mid-GET_OP, then the next byte is A.
        rx_byte(8'h55, 1); rx_byte(8'h66, 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_a", bus.o_alu_a, 0);
        check("mid_rst_b", bus.o_alu_b, 0);
        check("mid_rst_busy", bus.o_busy, 0);
`ifdef UART_ALU_SEQ_OVERRUN_EN
        check("mid_rst_overrun", bus.o_overrun, 0);
`endif
        rst = 1'b0;
        run_cmd(8'h11, 8'h02, 8'h20, 8'h13, "post_rst");
        check("post_rst_a", bus.o_alu_a, 8'h11);

        // Reset during transmission wait.
        rx_byte(8'h01, 1); rx_byte(8'h02, 1); rx_byte(8'h25, 1);
        get_tx(d, lat);
        check("or_result", d, 8'h03);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("tx_rst_busy", bus.o_busy, 0);
        run_cmd(8'h08, 8'h01, 8'h20, 8'h09, "after_tx_rst");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_alu_sequencer.md
Name: uart_alu_sequencer

Overview:
- Controller between the UART receiver, the UART transmitter and the combinational ALU.
- Collects three bytes from the receiver in order: operand A, operand B, opcode.
- Drives the ALU inputs with those bytes, captures the ALU result, launches one UART transmission of it, waits for completion, then re-arms for the next command.
- Includes an inter-byte timeout so that a partial command cannot leave the block stuck.

Parameters:
- NB_DATA, 8, data byte width; also the width of the ALU operands and result.
- NB_OP, 6, opcode width; taken from the low NB_OP bits of the third received byte.
- NB_TIMEOUT, 16, width of the inter-byte timeout counter.
- TIMEOUT_CYCLES, 50000, i_clock cycles allowed between bytes of one command.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  NB_DATA  byte from the receiver; valid when i_rx_done=1.
- i_rx_done  in  1  one-cycle pulse: byte received.
- i_tx_done  in  1  one-cycle pulse: transmitter finished the stop bit.
- i_alu_result  in  NB_DATA  combinational ALU output.
- o_alu_a  out  NB_DATA  registered operand A to the ALU.
- o_alu_b  out  NB_DATA  registered operand B to the ALU.
- o_alu_op  out  NB_OP  registered opcode to the ALU.
- o_tx_data  out  NB_DATA  registered byte to the transmitter.
- o_tx_start  out  1  one-cycle pulse: start transmission.
- o_busy  out  1  high from opcode accept until tx done.

Behaviour:
- Reset: state GET_A; all outputs 0; timeout counter 0. Reset wins over every other event, including mid-command and mid-transmission.
- States: GET_A, GET_B, GET_OP, EXEC, SEND, WAIT_TX (3-bit encoding).
- GET_A: on i_rx_done, o_alu_a <= i_rx_data, go to GET_B. No timeout is active in this state.
- GET_B: on i_rx_done, o_alu_b <= i_rx_data, go to GET_OP.
- GET_OP: on i_rx_done, o_alu_op <= i_rx_data[NB_OP-1:0], go to EXEC.
- EXEC (1 cycle): o_tx_data <= i_alu_result, go to SEND.
  - Result is sampled exactly one cycle after o_alu_op updates.
- SEND (1 cycle): o_tx_start=1, go to WAIT_TX.
- WAIT_TX: on i_tx_done, go to GET_A.
- o_busy=1 in EXEC, SEND and WAIT_TX; 0 otherwise.
- Latency: opcode i_rx_done at cycle N -> o_tx_start high at cycle N+2.
- o_tx_start is registered and is never high for more than one cycle per command.
- Timeout, in GET_B and GET_OP only:
  - The counter clears on every accepted byte and on entry to GET_A; otherwise it increments.
  - When the count reaches TIMEOUT_CYCLES-1 with no i_rx_done, go to GET_A.
  - o_alu_a, o_alu_b and o_alu_op keep their last values.
  - If i_rx_done coincides with expiry, the byte is accepted and the state advances normally.
- In EXEC, SEND and WAIT_TX, i_rx_done is ignored and the byte is dropped.
  - If i_rx_done and i_tx_done arrive together in WAIT_TX, go to GET_A and drop the byte.
- The counter saturates and does not wrap; its width must hold TIMEOUT_CYCLES.
- Unused state encodings return to GET_A on the next cycle.

Optional Feature:
- Macro: UART_ALU_SEQ_OVERRUN_EN.
- Defined:
  - Adds output o_overrun (1 bit, reset 0).
  - o_overrun is set on the cycle after any i_rx_done that is ignored (EXEC, SEND, WAIT_TX, including the simultaneous tx_done case).
  - It is sticky until i_reset.
  - A timeout expiry also sets it.
- Not defined: no port and no logic; dropped bytes and timeouts are silent.

Test Plan:
- Reset: hold i_reset 2 cycles mid-GET_OP -> all outputs 0, state GET_A; the next byte is taken as A.
- Normal command: rx 0x05, 0x03, 0x20; bench ALU ADD -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=6'h20; o_tx_data=0x08; o_tx_start pulses 1 cycle exactly 2 cycles after the third rx_done.
- Back-to-back: two commands, the second's A arriving 1 cycle after i_tx_done -> both results are transmitted in order; o_busy drops for at least 1 cycle between them.
- Timeout: TIMEOUT_CYCLES=20; rx 0xAA then idle 25 cycles, then 0x01, 0x02, 0x20 -> the 0x01 byte is taken as A, the result is 0x03, and no transmission is made for 0xAA.
- Drop during WAIT_TX: rx_done with 0xFF while busy -> state unaffected and o_alu_a unchanged; with UART_ALU_SEQ_OVERRUN_EN, o_overrun=1 and held.
- Simultaneous events: i_rx_done on the timeout-expiry cycle in GET_B -> byte accepted as B, advance to GET_OP.
